wts_channel_envelope: RTL and testbench
=======================================

// Module: wts_channel_envelope
// PURPOSE
//  Per-channel ADSR envelope generator. Sits directly upstream of wts_channel_volume.
//  Its 7-bit 'envelope' output drives that block's envelope input.
//  Runs on a prescaled tick and steps a 4-state ADSR machine (plus IDLE) from key_on/key_off pulses.
//  Attack, decay, sustain-level and release register values come from the channel register file.
// PARAMETERS
//  PRESCALE   64   clocks per envelope tick (>=2); prescaler counts 0..PRESCALE-1
// PORTS
//  clk         in   1  system clock; all logic on rising edge
//  reset       in   1  synchronous reset, active-high
//  key_on      in   1  single-cycle pulse: (re)start attack
//  key_off     in   1  single-cycle pulse: enter release
//  reg_ar      in   4  attack rate  (0 = hold, 15 = fastest)
//  reg_dr      in   4  decay rate   (0 = hold, 15 = fastest)
//  reg_sl      in   4  sustain level; sl_level = {reg_sl,3'b000} (0..120)
//  reg_rr      in   4  release rate (0 = hold, 15 = fastest)
//  envelope    out  7  unsigned envelope level, registered
//  env_state   out  3  0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
//  busy        out  1  env_state != IDLE (combinational from state register)
// BEHAVIOUR
//  Reset
//  - reset=1 at a rising edge sets: envelope=0, env_state=IDLE, prescaler=0, rate_cnt=0.
//  - Reset overrides all other inputs, including mid-operation.
//  Tick and step
//  - tick is high for one clock when prescaler==PRESCALE-1; the prescaler is free-running.
//  - Active rate r = reg_ar/reg_dr/reg_rr according to state.
//  - With r!=0, period P = 1<<(15-r) ticks. rate_cnt (14 bit) increments on each tick.
//  - step fires on a tick where rate_cnt==P-1; rate_cnt clears to 0 on that tick.
//  - r=0: no step ever (level holds). rate_cnt clears on every state transition.
//  - Register values are sampled live; a change takes effect at the next compare.
//  Transitions (priority top-down per cycle)
//  - key_on (any state, wins over a simultaneous key_off):
//      state <= ATTACK, envelope unchanged (restart from current level).
//  - key_off in ATTACK/DECAY/SUSTAIN: state <= RELEASE.
//  - key_off in IDLE or RELEASE: ignored; rate_cnt is not cleared.
//  - ATTACK: on step, envelope <= envelope+1. If that result ==127, state <= DECAY in the same edge.
//      If envelope is already 127 on entry, go to DECAY at the next edge without a step.
//  - DECAY: if envelope <= sl_level, state <= SUSTAIN (no step). Otherwise on step, envelope-1.
//  - SUSTAIN: envelope holds. A later sl change does not move the level.
//  - RELEASE: if envelope==0, state <= IDLE. Otherwise on step, envelope-1.
//  - IDLE: envelope holds at 0.
//  Width and timing rules
//  - envelope never wraps: it saturates at 127 going up and at 0 going down.
//  - key_on sampled at edge N gives env_state=ATTACK after edge N.
//  - The first envelope change comes at the first step after entry.
// TESTING
//  T1 reset held 3 clk, then key_off pulse -> envelope=0, env_state=0, busy=0 throughout.
//  T2 PRESCALE=4, ar=15, key_on -> envelope +1 every 4 clk.
//      It reaches 127 after 508 clk, and env_state=2 on that same edge.
//  T3 continue with dr=15, sl=8 -> envelope falls 1 per 4 clk to 64.
//      Then env_state=3, and envelope holds at 64 for 1000 clk.
//  T4 key_off in SUSTAIN, rr=14 -> envelope -1 every 8 clk.
//      At 0, env_state=0 and busy=0.
//  T5 in RELEASE at envelope=40, key_on and key_off on the same cycle.
//      -> env_state=1 and envelope rises from 40.
//  T6 ar=0 after key_on: envelope holds at its current level for 2000 clk.
//      Then reset for 1 clk -> envelope=0, env_state=0 on the next edge.

Source files
------------

// File: rtl/wts_channel_envelope.sv
// Per-channel ADSR envelope generator: prescaled tick, per-state rate counter,
// and a 7-bit saturating level that feeds the channel volume stage.
module wts_channel_envelope #(
  parameter int PRESCALE = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_on,
  input  logic       key_off,
  input  logic [3:0] reg_ar,
  input  logic [3:0] reg_dr,
  input  logic [3:0] reg_sl,
  input  logic [3:0] reg_rr,
  output logic [6:0] envelope,
  output logic [2:0] env_state,
  output logic       busy
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    envelope_q, envelope_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [13:0]   rate_cnt_q, rate_cnt_d;

  logic          tick;
  logic [3:0]    rate;
  logic [3:0]    shamt;
  logic [13:0]   period_m1;
  logic          step;
  logic [6:0]    sl_level;

  assign sl_level = {reg_sl, 3'b000};

  // Rate select and step detection.
  always_comb begin
    tick        = (prescaler_q == PRE_LAST);
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;

    rate = 4'd0;
    case (state_q)
      S_ATTACK:  rate = reg_ar;
      S_DECAY:   rate = reg_dr;
      S_RELEASE: rate = reg_rr;
      default:   rate = 4'd0;
    endcase

    // P-1 = (1 << (15-r)) - 1 equals 14'h3fff >> (r-1) for r in 1..15.
    shamt     = rate - 4'd1;
    period_m1 = 14'h3fff >> shamt;
    step      = tick && (rate != 4'd0) && (rate_cnt_q == period_m1);
  end

  // Next-state, level and rate counter.
  always_comb begin
    state_d    = state_q;
    envelope_d = envelope_q;
    rate_cnt_d = rate_cnt_q;

    if (tick) begin
      rate_cnt_d = step ? 14'd0 : rate_cnt_q + 14'd1;
    end

    if (key_on) begin
      state_d    = S_ATTACK;
      rate_cnt_d = 14'd0;
    end else if (key_off && (state_q == S_ATTACK || state_q == S_DECAY ||
                             state_q == S_SUSTAIN)) begin
      state_d    = S_RELEASE;
      rate_cnt_d = 14'd0;
    end else begin
      case (state_q)
        S_ATTACK: begin
          if (envelope_q == 7'd127) begin
            state_d    = S_DECAY;
            rate_cnt_d = 14'd0;
          end else if (step) begin
            envelope_d = envelope_q + 7'd1;
            if (envelope_q == 7'd126) begin
              state_d = S_DECAY;
            end
          end
        end
        S_DECAY: begin
          if (envelope_q <= sl_level) begin
            state_d    = S_SUSTAIN;
            rate_cnt_d = 14'd0;
          end else if (step) begin
            envelope_d = envelope_q - 7'd1;
          end
        end
        S_RELEASE: begin
          if (envelope_q == 7'd0) begin
            state_d    = S_IDLE;
            rate_cnt_d = 14'd0;
          end else if (step) begin
            envelope_d = envelope_q - 7'd1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      envelope_q  <= 7'd0;
      prescaler_q <= '0;
      rate_cnt_q  <= 14'd0;
    end else begin
      state_q     <= state_d;
      envelope_q  <= envelope_d;
      prescaler_q <= prescaler_d;
      rate_cnt_q  <= rate_cnt_d;
    end
  end

  assign envelope  = envelope_q;
  assign env_state = state_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_wts_channel_envelope.sv
// Directed bench for wts_channel_envelope with PRESCALE=4: a vector table of
// timed rows plus short sequences for the saturated-attack and slow-decay cases.
module tb_wts_channel_envelope;

  localparam int PRESCALE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_on = 1'b0;
  logic       key_off = 1'b0;
  logic [3:0] reg_ar = 4'd0;
  logic [3:0] reg_dr = 4'd0;
  logic [3:0] reg_sl = 4'd0;
  logic [3:0] reg_rr = 4'd0;
  logic [6:0] envelope;
  logic [2:0] env_state;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wts_channel_envelope #(.PRESCALE(PRESCALE)) dut (
    .clk      (clk),
    .reset    (reset),
    .key_on   (key_on),
    .key_off  (key_off),
    .reg_ar   (reg_ar),
    .reg_dr   (reg_dr),
    .reg_sl   (reg_sl),
    .reg_rr   (reg_rr),
    .envelope (envelope),
    .env_state(env_state),
    .busy     (busy)
  );

  // One row: drive rst/kon/koff for one edge, then idle edges, then compare.
  typedef struct {
    logic       rst;
    logic       kon;
    logic       koff;
    logic [3:0] ar;
    logic [3:0] dr;
    logic [3:0] sl;
    logic [3:0] rr;
    int         idle;
    int         exp_env;
    int         exp_state;
    int         exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic kon, logic koff,
                              logic [3:0] ar, logic [3:0] dr, logic [3:0] sl,
                              logic [3:0] rr, int idle, int e_env, int e_st,
                              int e_busy);
    vec_t v;
    v.rst = rst; v.kon = kon; v.koff = koff;
    v.ar = ar; v.dr = dr; v.sl = sl; v.rr = rr;
    v.idle = idle;
    v.exp_env = e_env; v.exp_state = e_st; v.exp_busy = e_busy;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input int e_env,
                               input int e_st, input int e_busy);
    $display("%s env=%0d state=%0d busy=%0d", tag, envelope, env_state, busy);
    check({tag, ".env"},   int'(envelope),  e_env);
    check({tag, ".state"}, int'(env_state), e_st);
    check({tag, ".busy"},  int'(busy),      e_busy);
  endtask

  initial begin
    // Edge index k counts non-reset edges after the last reset; ticks at k%4==0.
    vecs.push_back(mk(1,0,0, 15,15,8,14,    0,   0,0,0));
    vecs.push_back(mk(1,0,0, 15,15,8,14,    0,   0,0,0));
    vecs.push_back(mk(1,0,0, 15,15,8,14,    0,   0,0,0));
    vecs.push_back(mk(0,0,1, 15,15,8,14,    0,   0,0,0));  // k1 key_off in IDLE
    vecs.push_back(mk(0,0,0, 15,15,8,14,    0,   0,0,0));  // k2
    vecs.push_back(mk(0,1,0, 15,15,8,14,    0,   0,1,1));  // k3 key_on
    vecs.push_back(mk(0,0,0, 15,15,8,14,    0,   1,1,1));  // k4 first step
    vecs.push_back(mk(0,0,0, 15,15,8,14,    2,   1,1,1));  // k7
    vecs.push_back(mk(0,0,0, 15,15,8,14,    0,   2,1,1));  // k8
    vecs.push_back(mk(0,0,0, 15,15,8,14,  498, 126,1,1));  // k507
    vecs.push_back(mk(0,0,0, 15,15,8,14,    0, 127,2,1));  // k508 peak -> DECAY
    vecs.push_back(mk(0,0,0, 15,15,8,14,    2, 127,2,1));  // k511
    vecs.push_back(mk(0,0,0, 15,15,8,14,    0, 126,2,1));  // k512
    vecs.push_back(mk(0,0,0, 15,15,8,14,  247,  64,2,1));  // k760
    vecs.push_back(mk(0,0,0, 15,15,8,14,    0,  64,3,1));  // k761 SUSTAIN
    vecs.push_back(mk(0,0,0, 15,15,8,14,  999,  64,3,1));  // k1761
    vecs.push_back(mk(0,0,0, 15,15,0,14,    3,  64,3,1));  // k1765 sl change
    vecs.push_back(mk(0,0,1, 15,15,8,14,    0,  64,4,1));  // k1766 key_off
    vecs.push_back(mk(0,0,0, 15,15,8,14,    4,  64,4,1));  // k1771
    vecs.push_back(mk(0,0,0, 15,15,8,14,    0,  63,4,1));  // k1772 first release step
    vecs.push_back(mk(0,0,0, 15,15,8,14,  502,   1,4,1));  // k2275
    vecs.push_back(mk(0,0,0, 15,15,8,14,    0,   0,4,1));  // k2276
    vecs.push_back(mk(0,0,0, 15,15,8,14,    0,   0,0,0));  // k2277 IDLE
    vecs.push_back(mk(0,1,0, 15,15,8,14,    0,   0,1,1));  // k2278
    vecs.push_back(mk(0,0,0, 15,15,8,14,  157,  40,1,1));  // k2436
    vecs.push_back(mk(0,0,1, 15,15,8,14,    0,  40,4,1));  // k2437 RELEASE at 40
    vecs.push_back(mk(0,1,1, 15,15,8,14,    0,  40,1,1));  // k2438 key_on beats key_off
    vecs.push_back(mk(0,0,0, 15,15,8,14,    0,  40,1,1));  // k2439
    vecs.push_back(mk(0,0,0, 15,15,8,14,    0,  41,1,1));  // k2440
    vecs.push_back(mk(0,1,0,  0,15,8,14,    0,  41,1,1));  // k2441 ar=0
    vecs.push_back(mk(0,0,0,  0,15,8,14, 1999,  41,1,1));  // hold 2000 clk
    vecs.push_back(mk(1,0,0,  0,15,8,14,    0,   0,0,0));  // reset mid-attack

    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      reset   = vecs[i].rst;
      key_on  = vecs[i].kon;
      key_off = vecs[i].koff;
      reg_ar  = vecs[i].ar;
      reg_dr  = vecs[i].dr;
      reg_sl  = vecs[i].sl;
      reg_rr  = vecs[i].rr;
      tick_clk();
      reset   = 1'b0;
      key_on  = 1'b0;
      key_off = 1'b0;
      for (int j = 0; j < vecs[i].idle; j++) tick_clk();
      check_outputs($sformatf("row%0d", i), vecs[i].exp_env,
                    vecs[i].exp_state, vecs[i].exp_busy);
    end

    // Attack up to 127 with decay rate 0, then key_on at the peak.
    reg_ar = 4'd15; reg_dr = 4'd0; reg_sl = 4'd8; reg_rr = 4'd0;
    key_on = 1'b1;
    tick_clk();                                   // k1
    key_on = 1'b0;
    check_outputs("seq_kon", 0, 1, 1);
    repeat (507) tick_clk();                      // k508
    check_outputs("seq_peak", 127, 2, 1);
    key_on = 1'b1;
    tick_clk();                                   // k509
    key_on = 1'b0;
    check_outputs("seq_reattack", 127, 1, 1);
    tick_clk();                                   // k510
    check_outputs("seq_full_decay", 127, 2, 1);

    // Decay rate 13: period 4 ticks, first step at k524.
    reg_dr = 4'd13;
    repeat (12) tick_clk();                       // k522
    check_outputs("seq_dr13_a", 127, 2, 1);
    tick_clk();                                   // k523
    check_outputs("seq_dr13_b", 127, 2, 1);
    tick_clk();                                   // k524
    check_outputs("seq_dr13_c", 126, 2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
